// File: rtl/sram_like_arbiter.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : sram_like_arbiter
// Purpose  : N-channel sram-like master arbiter with in-order response routing.
// Revision : 1.0
// ============================================================================
module sram_like_arbiter #(
  parameter  int NUM_CH   = 2,
  parameter  int ADDR_W   = 32,
  parameter  int DATA_W   = 32,
  parameter  int MAX_OUTS = 4,
  parameter  int ARB_MODE = 0,
  localparam int STRB_W   = DATA_W / 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [NUM_CH-1:0]        m_req,
  input  logic [NUM_CH-1:0]        m_wr,
  input  logic [2*NUM_CH-1:0]      m_size,
  input  logic [STRB_W*NUM_CH-1:0] m_wstrb,
  input  logic [ADDR_W*NUM_CH-1:0] m_addr,
  input  logic [DATA_W*NUM_CH-1:0] m_wdata,
  output logic [NUM_CH-1:0]        m_addr_ok,
  output logic [NUM_CH-1:0]        m_data_ok,
  output logic [DATA_W-1:0]        m_rdata,
  output logic                     s_req,
  output logic                     s_wr,
  output logic [1:0]               s_size,
  output logic [STRB_W-1:0]        s_wstrb,
  output logic [ADDR_W-1:0]        s_addr,
  output logic [DATA_W-1:0]        s_wdata,
  input  logic                     s_addr_ok,
  input  logic                     s_data_ok,
  input  logic [DATA_W-1:0]        s_rdata,
  output logic                     err
);

  localparam int c_ch_w  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int c_ptr_w = $clog2(MAX_OUTS);
  localparam int c_cnt_w = c_ptr_w + 1;

  logic [c_ch_w-1:0]  r_fifo [MAX_OUTS];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;
  logic [c_ch_w-1:0]  r_rr_ptr;
  logic               r_lock_valid;
  logic [c_ch_w-1:0]  r_lock_ch;
  logic               r_err;

  logic               w_any;
  logic [c_ch_w-1:0]  w_fix_g;
  logic [c_ch_w-1:0]  w_rr_g;
  logic               w_rr_found;
  logic [c_ch_w-1:0]  w_idx;
  logic               w_lock_hold;
  logic               w_violation;
  logic [c_ch_w-1:0]  w_grant;
  logic               w_full;
  logic               w_empty;
  logic               w_xfer;
  logic               w_pop;

  always_comb begin
    w_any      = |m_req;
    w_fix_g    = '0;
    w_rr_g     = '0;
    w_rr_found = 1'b0;
    w_idx      = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (m_req[c_ch_w'(k)]) w_fix_g = c_ch_w'(k);
    end
    for (int k = 0; k < NUM_CH; k++) begin
      w_idx = c_ch_w'((int'(r_rr_ptr) + k) % NUM_CH);
      if (!w_rr_found && m_req[w_idx]) begin
        w_rr_found = 1'b1;
        w_rr_g     = w_idx;
      end
    end
    // A lock whose owner withdrew is void; normal arbitration takes over that cycle.
    w_lock_hold = r_lock_valid && m_req[r_lock_ch];
    w_violation = r_lock_valid && !m_req[r_lock_ch];
    if (w_lock_hold)        w_grant = r_lock_ch;
    else if (ARB_MODE == 1) w_grant = w_rr_g;
    else                    w_grant = w_fix_g;
  end

  assign w_full  = (r_count == c_cnt_w'(MAX_OUTS));
  assign w_empty = (r_count == '0);
  assign s_req   = resetn && w_any && !w_full;
  assign w_xfer  = s_req && s_addr_ok;
  assign w_pop   = resetn && s_data_ok && !w_empty;

  assign s_wr    = m_wr[w_grant];
  assign s_size  = m_size[w_grant*2 +: 2];
  assign s_wstrb = m_wstrb[w_grant*STRB_W +: STRB_W];
  assign s_addr  = m_addr[w_grant*ADDR_W +: ADDR_W];
  assign s_wdata = m_wdata[w_grant*DATA_W +: DATA_W];

  assign m_addr_ok = w_xfer ? (NUM_CH'(1) << w_grant) : '0;
  assign m_data_ok = w_pop ? (NUM_CH'(1) << r_fifo[r_rd_ptr]) : '0;
  assign m_rdata   = s_rdata;
  assign err       = r_err;

  always_ff @(posedge clk) begin
    if (resetn && w_xfer) r_fifo[r_wr_ptr] <= w_grant;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_rr_ptr     <= '0;
      r_lock_valid <= 1'b0;
      r_lock_ch    <= '0;
      r_err        <= 1'b0;
    end else begin
      if (w_xfer) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_xfer && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_xfer && w_pop) r_count <= r_count - 1'b1;
      if (w_xfer) r_rr_ptr <= (w_grant == c_ch_w'(NUM_CH - 1)) ? '0 : w_grant + 1'b1;
      if (w_xfer) begin
        r_lock_valid <= 1'b0;
      end else if (s_req) begin
        r_lock_valid <= 1'b1;
        r_lock_ch    <= w_grant;
      end else begin
        r_lock_valid <= 1'b0;
      end
      if ((s_data_ok && w_empty) || w_violation) r_err <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_like_arbiter.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : tb_sram_like_arbiter
// Purpose  : Directed bench; fixed-priority and round-robin instances vs. model.
// Revision : 1.0
// ============================================================================
module tb_sram_like_arbiter;

  logic        clk;
  logic        resetn;
  logic [1:0]  m_req;
  logic [1:0]  m_wr;
  logic [3:0]  m_size;
  logic [7:0]  m_wstrb;
  logic [63:0] m_addr;
  logic [63:0] m_wdata;
  logic        s_addr_ok;
  logic        s_data_ok;
  logic [31:0] s_rdata;

  logic [1:0]  dut_aok   [2];
  logic [1:0]  dut_dok   [2];
  logic [31:0] dut_rdata [2];
  logic        dut_sreq  [2];
  logic        dut_swr   [2];
  logic [1:0]  dut_ssize [2];
  logic [3:0]  dut_swstrb[2];
  logic [31:0] dut_saddr [2];
  logic [31:0] dut_swdata[2];
  logic        dut_err   [2];

  int n_vec = 0;
  int n_bad = 0;

  // Model state per instance (0 = fixed priority, 1 = round-robin).
  int q_fix[$];
  int q_rr[$];
  int mlock [2];
  int mrr   [2];
  bit merr  [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    sram_like_arbiter #(
      .NUM_CH(2), .ADDR_W(32), .DATA_W(32), .MAX_OUTS(4), .ARB_MODE(gi)
    ) u_dut (
      .clk(clk), .resetn(resetn),
      .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_wstrb(m_wstrb),
      .m_addr(m_addr), .m_wdata(m_wdata),
      .m_addr_ok(dut_aok[gi]), .m_data_ok(dut_dok[gi]), .m_rdata(dut_rdata[gi]),
      .s_req(dut_sreq[gi]), .s_wr(dut_swr[gi]), .s_size(dut_ssize[gi]),
      .s_wstrb(dut_swstrb[gi]), .s_addr(dut_saddr[gi]), .s_wdata(dut_swdata[gi]),
      .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
      .err(dut_err[gi])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int qsize(int d);
    return (d == 0) ? q_fix.size() : q_rr.size();
  endfunction

  function automatic int qhead(int d);
    return (d == 0) ? q_fix[0] : q_rr[0];
  endfunction

  function automatic int exp_grant(int d);
    if (mlock[d] >= 0 && m_req[mlock[d]]) return mlock[d];
    for (int k = 0; k < 2; k++) begin
      int idx = (d == 0) ? k : (mrr[d] + k) % 2;
      if (m_req[idx]) return idx;
    end
    return 0;
  endfunction

  // Inputs are stable from negedge to the next posedge, so check and advance here.
  initial begin
    for (int d = 0; d < 2; d++) begin
      mlock[d] = -1;
      mrr[d]   = 0;
      merr[d]  = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        int  g;
        bit  e_sreq;
        bit  xfer;
        bit  viol;
        logic [1:0] e_aok;
        logic [1:0] e_dok;
        g      = exp_grant(d);
        e_sreq = resetn && (m_req != 2'b00) && (qsize(d) < 4);
        xfer   = e_sreq && s_addr_ok;
        e_aok  = xfer ? 2'(1 << g) : 2'b00;
        e_dok  = (resetn && s_data_ok && qsize(d) > 0) ? 2'(1 << qhead(d)) : 2'b00;
        chk($sformatf("s_req[%0d]", d), 32'(dut_sreq[d]), 32'(e_sreq));
        chk($sformatf("addr_ok[%0d]", d), 32'(dut_aok[d]), 32'(e_aok));
        chk($sformatf("data_ok[%0d]", d), 32'(dut_dok[d]), 32'(e_dok));
        chk($sformatf("err[%0d]", d), 32'(dut_err[d]), 32'(merr[d]));
        if (e_dok != 2'b00) chk($sformatf("rdata[%0d]", d), dut_rdata[d], s_rdata);
        if (e_sreq) begin
          chk($sformatf("s_addr[%0d]", d), dut_saddr[d], m_addr[g*32 +: 32]);
          chk($sformatf("s_wdata[%0d]", d), dut_swdata[d], m_wdata[g*32 +: 32]);
          chk($sformatf("s_ctl[%0d]", d), {25'd0, dut_swr[d], dut_ssize[d], dut_swstrb[d]},
              {25'd0, m_wr[g], m_size[g*2 +: 2], m_wstrb[g*4 +: 4]});
        end
        if (!resetn) begin
          if (d == 0) q_fix.delete(); else q_rr.delete();
          mlock[d] = -1;
          mrr[d]   = 0;
          merr[d]  = 1'b0;
        end else begin
          viol = (mlock[d] >= 0) && !m_req[mlock[d]];
          if (s_data_ok) begin
            if (qsize(d) == 0) merr[d] = 1'b1;
            else if (d == 0) void'(q_fix.pop_front());
            else void'(q_rr.pop_front());
          end
          if (xfer) begin
            if (d == 0) q_fix.push_back(g); else q_rr.push_back(g);
            mrr[d] = (g + 1) % 2;
          end
          if (viol) merr[d] = 1'b1;
          mlock[d] = xfer ? -1 : (e_sreq ? g : -1);
        end
      end
    end
  end

  task automatic drive(input bit rn, input bit [1:0] req, input bit aok, input bit dok,
                       input logic [31:0] rd);
    resetn    = rn;
    m_req     = req;
    s_addr_ok = aok;
    s_data_ok = dok;
    s_rdata   = rd;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn    = 1'b0;
    m_req     = 2'b00;
    m_wr      = 2'b10;
    m_size    = {2'd1, 2'd2};
    m_wstrb   = {4'h3, 4'hf};
    m_addr    = {32'h2000_0080, 32'h1000_0040};
    m_wdata   = {32'h5555_1111, 32'hAAAA_0000};
    s_addr_ok = 1'b0;
    s_data_ok = 1'b0;
    s_rdata   = 32'h0;
    repeat (2) @(posedge clk);
    #1;

    // Both channels request: fixed starves ch1, round-robin alternates.
    drive(1, 2'b11, 1, 0, 0);
    chk("fix_g0", 32'(dut_aok[0]), 32'h1);
    chk("fix_addr0", dut_saddr[0], 32'h1000_0040);
    chk("rr_g0", 32'(dut_aok[1]), 32'h1);
    tick();
    drive(1, 2'b11, 1, 0, 0);
    chk("fix_g1", 32'(dut_aok[0]), 32'h1);
    chk("rr_g1", 32'(dut_aok[1]), 32'h2);
    tick();
    drive(1, 2'b11, 1, 0, 0);
    chk("fix_g2", 32'(dut_aok[0]), 32'h1);
    chk("rr_g2", 32'(dut_aok[1]), 32'h1);
    tick();
    drive(1, 2'b10, 1, 0, 0);
    chk("fix_g3", 32'(dut_aok[0]), 32'h2);
    chk("rr_g3", 32'(dut_aok[1]), 32'h2);
    tick();
    drive(1, 2'b00, 0, 1, 32'h1234_5678);
    chk("fix_r0", 32'(dut_dok[0]), 32'h1);
    chk("fix_rdata", dut_rdata[0], 32'h1234_5678);
    chk("rr_r0", 32'(dut_dok[1]), 32'h1);
    tick();
    drive(1, 2'b00, 0, 1, 32'hCAFE_0001);
    chk("rr_r1", 32'(dut_dok[1]), 32'h2);
    tick();
    drive(1, 2'b00, 0, 1, 32'hCAFE_0002);
    chk("rr_r2", 32'(dut_dok[1]), 32'h1);
    tick();
    drive(1, 2'b00, 0, 1, 32'hCAFE_0003);
    chk("fix_r3", 32'(dut_dok[0]), 32'h2);
    chk("rr_r3", 32'(dut_dok[1]), 32'h2);
    tick();

    // Lock: ch1 stalls, ch0 arrives but must wait.
    drive(1, 2'b10, 0, 0, 0);
    chk("lock_addr0", dut_saddr[0], 32'h2000_0080);
    chk("lock_aok0", 32'(dut_aok[0]), 32'h0);
    tick();
    drive(1, 2'b11, 0, 0, 0);
    chk("lock_addr1", dut_saddr[0], 32'h2000_0080);
    chk("lock_addr1_rr", dut_saddr[1], 32'h2000_0080);
    tick();
    drive(1, 2'b11, 0, 0, 0);
    chk("lock_addr2", dut_saddr[0], 32'h2000_0080);
    tick();
    drive(1, 2'b11, 1, 0, 0);
    chk("lock_xfer", 32'(dut_aok[0]), 32'h2);
    tick();
    drive(1, 2'b01, 1, 0, 0);
    chk("lock_next", 32'(dut_aok[0]), 32'h1);
    tick();
    drive(1, 2'b00, 0, 1, 32'h0000_00A1);
    chk("lock_r0", 32'(dut_dok[0]), 32'h2);
    tick();
    drive(1, 2'b00, 0, 1, 32'h0000_00A0);
    chk("lock_r1", 32'(dut_dok[0]), 32'h1);
    tick();

    // Full: four accepts, then stall despite a same-cycle response.
    for (int i = 0; i < 4; i++) begin
      drive(1, 2'b01, 1, 0, 0);
      tick();
    end
    drive(1, 2'b01, 1, 1, 32'hF000_0000);
    chk("full_sreq", 32'(dut_sreq[0]), 32'h0);
    chk("full_aok", 32'(dut_aok[0]), 32'h0);
    chk("full_dok", 32'(dut_dok[0]), 32'h1);
    tick();
    drive(1, 2'b01, 1, 0, 0);
    chk("unfull_sreq", 32'(dut_sreq[0]), 32'h1);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1, 2'b00, 0, 1, 32'hF000_0001 + 32'(i));
      tick();
    end

    // Protocol error: response with nothing outstanding.
    drive(1, 2'b00, 0, 1, 32'hDEAD_BEEF);
    chk("orphan_dok", 32'(dut_dok[0]), 32'h0);
    tick();
    drive(1, 2'b00, 0, 0, 0);
    chk("err_set", 32'(dut_err[0]), 32'h1);
    chk("err_set_rr", 32'(dut_err[1]), 32'h1);
    tick();
    drive(1, 2'b00, 0, 0, 0);
    chk("err_hold", 32'(dut_err[0]), 32'h1);
    tick();
    drive(0, 2'b01, 1, 0, 0);
    chk("rst_sreq", 32'(dut_sreq[0]), 32'h0);
    chk("rst_aok", 32'(dut_aok[0]), 32'h0);
    tick();
    drive(1, 2'b01, 1, 0, 0);
    chk("err_clear", 32'(dut_err[0]), 32'h0);
    tick();
    drive(1, 2'b01, 1, 0, 0);
    tick();
    drive(0, 2'b00, 0, 0, 0);
    tick();
    drive(1, 2'b00, 0, 1, 32'h0BAD_0BAD);
    chk("drop_dok", 32'(dut_dok[0]), 32'h0);
    tick();
    drive(1, 2'b00, 0, 0, 0);
    chk("drop_err", 32'(dut_err[0]), 32'h1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sram_like_arbiter.md
# sram_like_arbiter

Parametrised arbiter merging NUM_CH sram-like request/response master channels onto one sram-like slave port. It sits between the CPU pipeline (instruction fetch, data access, future extra ports) and the memory bridge, succeeding the fixed single-cycle inst/data SRAM pair. It supports multiple outstanding requests with in-order response routing, and selectable fixed-priority or round-robin arbitration.

## Interface
Parameters:
- NUM_CH, 2: number of master channels (2..8); channel 0 = instruction fetch, channel 1 = data.
- ADDR_W, 32: address width.
- DATA_W, 32: data width; STRB_W = DATA_W/8.
- MAX_OUTS, 4: max outstanding accepted-but-unanswered requests; power of two, 2..16.
- ARB_MODE, 0: 0 = fixed priority (lowest index wins); 1 = round-robin.

Ports (per-channel signals flattened, channel i at slice i):
- clk  in  1  sole clock, rising edge.
- resetn  in  1  synchronous reset, active-low.
- m_req  in  NUM_CH  request valid per channel.
- m_wr  in  NUM_CH  1 = write.
- m_size  in  2*NUM_CH  access size (0 = byte, 1 = half, 2 = word).
- m_wstrb  in  STRB_W*NUM_CH  write byte enables.
- m_addr  in  ADDR_W*NUM_CH  address.
- m_wdata  in  DATA_W*NUM_CH  write data.
- m_addr_ok  out  NUM_CH  request accepted this cycle.
- m_data_ok  out  NUM_CH  response for the oldest outstanding request of that channel.
- m_rdata  out  DATA_W  read data, shared by all channels; qualified by m_data_ok.
- s_req, s_wr, s_size, s_wstrb, s_addr, s_wdata  out  1/1/2/STRB_W/ADDR_W/DATA_W  slave request.
- s_addr_ok  in  1  slave accepted request.
- s_data_ok  in  1  slave response (in order).
- s_rdata  in  DATA_W  slave read data.
- err  out  1  sticky protocol-error flag.

## Operation
- Handshake: a request transfers when s_req && s_addr_ok; the same cycle m_addr_ok[g] = 1 for the granted channel g only. Masters hold req and payload stable until addr_ok.
- Grant: when unlocked, choose among m_req by ARB_MODE. Fixed: lowest index. Round-robin: search starts at rr_ptr; after each transfer, rr_ptr <= g+1 mod NUM_CH.
- Lock: if s_req=1 and s_addr_ok=0, register lock_valid=1 and lock_ch=g. While locked, grant is forced to lock_ch regardless of other requests. Lock clears on transfer.
- If the locked master drops req (protocol violation): set err, clear lock.
- s_req = (any m_req) && !full. Slave payload muxed from the granted channel.
- ID FIFO, depth MAX_OUTS, stores the granted channel index, ceil(log2(NUM_CH)) bits.
  - Push on transfer.
  - Pop on s_data_ok.
  - Write/read pointers wrap modulo MAX_OUTS.
  - count is log2(MAX_OUTS)+1 bits.
- Full (count==MAX_OUTS) blocks push even when a pop happens the same cycle. Simultaneous push and pop when not full leaves count unchanged.
- Response routing: m_data_ok[head] = s_data_ok when not empty; m_rdata = s_rdata passthrough.
- s_data_ok when empty: set err, no m_data_ok, no pointer change.
- err clears only on reset.
- Reset (resetn=0 at posedge):
  - FIFO empty, pointers 0, count 0.
  - rr_ptr 0, lock_valid 0, err 0.
  - All m_addr_ok/m_data_ok/s_req low while resetn=0.
  - Reset mid-transaction drops all outstanding IDs; later s_data_ok flags err.

## Timing
- Request path is combinational: m_req to s_req, s_addr_ok to m_addr_ok. Zero added latency.
- Response path is combinational: s_data_ok to m_data_ok. Zero added latency.
- Throughput: one accepted request per cycle and one response per cycle, concurrently.
- Lock state, FIFO, rr_ptr and err update at posedge. A new grant decision is visible in the cycle after a stall.
- A response may arrive in the same cycle its request is accepted only if the FIFO was non-empty (pop targets the head, not the new entry).
- Max outstanding = MAX_OUTS. In the cycle count==MAX_OUTS, s_req=0.

## Test plan
- Setup for all cases: NUM_CH=2, MAX_OUTS=4.
- Fixed mode, both channels request, s_addr_ok=1:
  - Expect ch0 granted each cycle, m_addr_ok=2'b01, and ch1 starved until ch0 drops req.
  - Then respond s_data_ok with s_rdata=0x1234_5678; expect m_data_ok=2'b01, m_rdata=0x12345678.
- Round-robin mode, both channels request continuously:
  - Expect grants alternate 0,1,0,1.
  - Expect 4 s_data_ok pulses routed to 01,10,01,10.
- Lock: ch1 requests alone, s_addr_ok=0 for 3 cycles, ch0 raises req in cycle 1:
  - Expect s_addr stays ch1's address.
  - On s_addr_ok, expect m_addr_ok=2'b10, then ch0 granted next.
- Full: 4 accepts with no responses.
  - Expect s_req=0 in cycle 5 even with s_data_ok=1 that cycle.
  - Next cycle (count 3), expect s_req=1.
  - Pointers wrap after the 5th push.
- Protocol errors: s_data_ok with an empty FIFO.
  - Expect err=1, m_data_ok=0, err held until resetn=0.
  - Reset with 2 outstanding requests, then s_data_ok: expect err=1.
